// File: rtl/ptmch_pkg.sv
// Shared types and default widths for the programmable trigger sequencer.
// The is_busy helper groups the four burst-phase states.
package ptmch_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DELAY,
        ST_PULSE,
        ST_GAP,
        ST_HOLDOFF
    } trg_seq_state_t;

    localparam int TRG_CNT_W  = 16;
    localparam int TRG_REP_W  = 8;
    localparam int TRG_STAT_W = 16;

    function automatic logic is_busy(input trg_seq_state_t s);
        return (s inside {ST_DELAY, ST_PULSE, ST_GAP, ST_HOLDOFF});
    endfunction

endpackage

// File: rtl/ptmch_trg_seq_if.sv
// Host-facing control, configuration and status bundle of the trigger sequencer.
// The master side is the host or bench; the slave side is the sequencer.
interface ptmch_trg_seq_if #(
    parameter int CNT_W  = 16,
    parameter int REP_W  = 8,
    parameter int STAT_W = 16
);
    logic              ARM;
    logic              ABORT;
    logic              TRG_IN;
    logic [CNT_W-1:0]  CFG_DELAY;
    logic [CNT_W-1:0]  CFG_WIDTH;
    logic [CNT_W-1:0]  CFG_GAP;
    logic [REP_W-1:0]  CFG_REPEAT;
    logic [CNT_W-1:0]  CFG_HOLDOFF;
    logic              CFG_ONESHOT;
    logic              TRG_OUT;
    logic              ARMED_O;
    logic              BUSY;
    logic              DONE;
    logic [STAT_W-1:0] EVT_CNT;
    logic [STAT_W-1:0] MISS_CNT;

    modport master (
        output ARM, ABORT, TRG_IN,
        output CFG_DELAY, CFG_WIDTH, CFG_GAP, CFG_REPEAT, CFG_HOLDOFF, CFG_ONESHOT,
        input  TRG_OUT, ARMED_O, BUSY, DONE, EVT_CNT, MISS_CNT
    );

    modport slave (
        input  ARM, ABORT, TRG_IN,
        input  CFG_DELAY, CFG_WIDTH, CFG_GAP, CFG_REPEAT, CFG_HOLDOFF, CFG_ONESHOT,
        output TRG_OUT, ARMED_O, BUSY, DONE, EVT_CNT, MISS_CNT
    );

endinterface

// File: rtl/ptmch_sat_cnt.sv
// Saturating up-counter with synchronous clear; sticks at all-ones and never wraps.
module ptmch_sat_cnt #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + W'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/ptmch_trg_seq.sv
// Trigger sequencer: arms, qualifies the rising edge of TRG_IN, emits a delayed
// burst of TRG_OUT pulses, applies holdoff, and counts accepted/missed triggers.
module ptmch_trg_seq
    import ptmch_pkg::*;
#(
    parameter int CNT_W  = TRG_CNT_W,
    parameter int REP_W  = TRG_REP_W,
    parameter int STAT_W = TRG_STAT_W
) (
    input  logic           CLK160M,
    input  logic           RESET_N,
    ptmch_trg_seq_if.slave bus
);

    trg_seq_state_t   r_state, w_nxt, w_exit;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [REP_W-1:0] r_rep, w_rep_nxt;
    logic [CNT_W-1:0] r_width_m1, r_gap_m1, r_hold;
    logic             r_oneshot;
    logic             r_trg_q;
    logic             r_trg_out, r_armed, r_busy, r_done;
    logic             w_rise, w_accept, w_miss, w_done_nxt;

    // Fields of zero behave as one; the stored value is the reload (length - 1).
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    always_comb begin
        w_rise     = bus.TRG_IN & ~r_trg_q;
        w_accept   = (r_state == ST_ARMED) && w_rise && !bus.ABORT;
        w_miss     = w_rise && is_busy(r_state);
        w_exit     = r_oneshot ? ST_IDLE : ST_ARMED;
        w_nxt      = r_state;
        w_cnt_nxt  = r_cnt;
        w_rep_nxt  = r_rep;
        if (bus.ABORT) begin
            w_nxt = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.ARM) w_nxt = ST_ARMED;
                end
                ST_ARMED: begin
                    if (w_rise) begin
                        w_rep_nxt = (bus.CFG_REPEAT == '0) ? REP_W'(1) : bus.CFG_REPEAT;
                        if (bus.CFG_DELAY == '0) begin
                            w_nxt     = ST_PULSE;
                            w_cnt_nxt = len_m1(bus.CFG_WIDTH);
                        end else begin
                            w_nxt     = ST_DELAY;
                            w_cnt_nxt = bus.CFG_DELAY - CNT_W'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (r_cnt == '0) begin
                        w_nxt     = ST_PULSE;
                        w_cnt_nxt = r_width_m1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_PULSE: begin
                    if (r_cnt != '0) begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end else if (r_rep > REP_W'(1)) begin
                        w_nxt     = ST_GAP;
                        w_cnt_nxt = r_gap_m1;
                        w_rep_nxt = r_rep - REP_W'(1);
                    end else begin
                        w_rep_nxt = '0;
                        if (r_hold == '0) begin
                            w_nxt = w_exit;
                        end else begin
                            w_nxt     = ST_HOLDOFF;
                            w_cnt_nxt = r_hold - CNT_W'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (r_cnt == '0) begin
                        w_nxt     = ST_PULSE;
                        w_cnt_nxt = r_width_m1;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                ST_HOLDOFF: begin
                    if (r_cnt == '0) begin
                        w_nxt = w_exit;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
                default: w_nxt = ST_IDLE;
            endcase
        end
        // DONE marks the final high cycle of the last pulse in the burst.
        w_done_nxt = (w_nxt == ST_PULSE) && (w_cnt_nxt == '0) && (w_rep_nxt == REP_W'(1));
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nxt;
        end
    end

    always_ff @(posedge CLK160M or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt      <= '0;
            r_rep      <= '0;
            r_trg_q    <= 1'b0;
            r_trg_out  <= 1'b0;
            r_armed    <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_width_m1 <= '0;
            r_gap_m1   <= '0;
            r_hold     <= '0;
            r_oneshot  <= 1'b1;
        end else begin
            r_cnt     <= w_cnt_nxt;
            r_rep     <= w_rep_nxt;
            r_trg_q   <= bus.TRG_IN;
            r_trg_out <= (w_nxt == ST_PULSE);
            r_armed   <= (w_nxt == ST_ARMED);
            r_busy    <= is_busy(w_nxt);
            r_done    <= w_done_nxt;
            // Shadow copy keeps host writes from disturbing a burst in flight.
            if (w_accept) begin
                r_width_m1 <= len_m1(bus.CFG_WIDTH);
                r_gap_m1   <= len_m1(bus.CFG_GAP);
                r_hold     <= bus.CFG_HOLDOFF;
                r_oneshot  <= bus.CFG_ONESHOT;
            end
        end
    end

    ptmch_sat_cnt #(.W(STAT_W)) u_evt_cnt (
        .i_clk   (CLK160M),
        .i_rst_n (RESET_N),
        .i_inc   (w_accept),
        .i_clr   (1'b0),
        .o_cnt   (bus.EVT_CNT)
    );

    ptmch_sat_cnt #(.W(STAT_W)) u_miss_cnt (
        .i_clk   (CLK160M),
        .i_rst_n (RESET_N),
        .i_inc   (w_miss),
        .i_clr   (1'b0),
        .o_cnt   (bus.MISS_CNT)
    );

    assign bus.TRG_OUT = r_trg_out;
    assign bus.ARMED_O = r_armed;
    assign bus.BUSY    = r_busy;
    assign bus.DONE    = r_done;

endmodule

// File: tb/tb_ptmch_trg_seq.sv
// Directed bench for the trigger sequencer: burst timing, zero fields, holdoff/miss,
// abort, counter saturation on a narrow build, and asynchronous reset.
module tb_ptmch_trg_seq;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    ptmch_trg_seq_if #(.CNT_W(16), .REP_W(8), .STAT_W(16)) ifm ();
    ptmch_trg_seq_if #(.CNT_W(16), .REP_W(8), .STAT_W(4))  ifs ();

    ptmch_trg_seq #(.CNT_W(16), .REP_W(8), .STAT_W(16)) u_dut (
        .CLK160M (clk),
        .RESET_N (rst_n),
        .bus     (ifm)
    );

    ptmch_trg_seq #(.CNT_W(16), .REP_W(8), .STAT_W(4)) u_dut_s (
        .CLK160M (clk),
        .RESET_N (rst_n),
        .bus     (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expected TRG_OUT after edge k, rise taken at edge 1, effective field values.
    function automatic logic exp_trg(input int k, input int d, input int w, input int g, input int r);
        int p;
        int per;
        p   = k - 1 - d;
        per = w + g;
        if (p < 0 || p >= r * per - g) return 1'b0;
        return ((p % per) < w);
    endfunction

    function automatic logic exp_done(input int k, input int d, input int w, input int g, input int r);
        return ((k - 1 - d) == (r * (w + g) - g - 1));
    endfunction

    task automatic set_cfg(input int d, input int w, input int g, input int r, input int h, input logic os);
        ifm.CFG_DELAY   = 16'(d);
        ifm.CFG_WIDTH   = 16'(w);
        ifm.CFG_GAP     = 16'(g);
        ifm.CFG_REPEAT  = 8'(r);
        ifm.CFG_HOLDOFF = 16'(h);
        ifm.CFG_ONESHOT = os;
    endtask

    task automatic arm();
        ifm.ARM = 1'b1;
        tick();
        ifm.ARM = 1'b0;
    endtask

    // Rise seen at edge 1 (and optionally at edge rise2); checks TRG_OUT/DONE each cycle.
    task automatic burst(input string tag, input int d, input int w, input int g, input int r,
                         input int ncyc, input int rise2);
        ifm.TRG_IN = 1'b1;
        for (int k = 1; k <= ncyc; k++) begin
            if (k == rise2) ifm.TRG_IN = 1'b1;
            tick();
            if (k == 1 || k == rise2) ifm.TRG_IN = 1'b0;
            check_val($sformatf("%s trg k=%0d", tag, k), 32'(ifm.TRG_OUT), 32'(exp_trg(k, d, w, g, r)));
            check_val($sformatf("%s done k=%0d", tag, k), 32'(ifm.DONE), 32'(exp_done(k, d, w, g, r)));
        end
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        ifm.ARM = 1'b0; ifm.ABORT = 1'b0; ifm.TRG_IN = 1'b0;
        ifs.ARM = 1'b0; ifs.ABORT = 1'b0; ifs.TRG_IN = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 1'b1);
        ifs.CFG_DELAY = 16'd1; ifs.CFG_WIDTH = 16'd1; ifs.CFG_GAP = 16'd1;
        ifs.CFG_REPEAT = 8'd1; ifs.CFG_HOLDOFF = 16'd0; ifs.CFG_ONESHOT = 1'b1;
        tick();
        tick();
        check_val("rst trg_out", 32'(ifm.TRG_OUT), 0);
        check_val("rst armed",   32'(ifm.ARMED_O), 0);
        check_val("rst busy",    32'(ifm.BUSY), 0);
        check_val("rst done",    32'(ifm.DONE), 0);
        check_val("rst evt",     32'(ifm.EVT_CNT), 0);
        check_val("rst miss",    32'(ifm.MISS_CNT), 0);
        rst_n = 1'b1;
        tick();

        // Edge while idle is ignored
        ifm.TRG_IN = 1'b1;
        tick();
        ifm.TRG_IN = 1'b0;
        tick();
        check_val("idle edge busy", 32'(ifm.BUSY), 0);
        check_val("idle edge evt",  32'(ifm.EVT_CNT), 0);

        // Single delayed wide pulse, one-shot
        set_cfg(3, 15, 1, 1, 0, 1'b1);
        arm();
        check_val("t1 armed", 32'(ifm.ARMED_O), 1);
        burst("t1", 3, 15, 1, 1, 19, 0);
        check_val("t1 armed end", 32'(ifm.ARMED_O), 0);
        check_val("t1 busy end",  32'(ifm.BUSY), 0);
        check_val("t1 evt",       32'(ifm.EVT_CNT), 1);

        // Three-pulse burst with gaps
        set_cfg(0, 2, 3, 3, 0, 1'b1);
        arm();
        burst("t2", 0, 2, 3, 3, 15, 0);
        check_val("t2 busy end", 32'(ifm.BUSY), 0);

        // Zero width/gap/repeat behave as one
        set_cfg(0, 0, 0, 0, 0, 1'b1);
        arm();
        burst("t3", 0, 1, 1, 1, 4, 0);
        check_val("t3 busy end", 32'(ifm.BUSY), 0);
        check_val("t3 evt",      32'(ifm.EVT_CNT), 3);

        // Re-arm after holdoff; second rise during the burst is a miss
        set_cfg(2, 3, 1, 1, 10, 1'b0);
        arm();
        burst("t4", 2, 3, 1, 1, 15, 6);
        check_val("t4 armed k15", 32'(ifm.ARMED_O), 0);
        check_val("t4 busy k15",  32'(ifm.BUSY), 1);
        tick();
        check_val("t4 armed k16", 32'(ifm.ARMED_O), 1);
        check_val("t4 busy k16",  32'(ifm.BUSY), 0);
        check_val("t4 miss",      32'(ifm.MISS_CNT), 1);
        check_val("t4 evt",       32'(ifm.EVT_CNT), 4);

        // Rise on the holdoff exit cycle is a miss, not a new trigger
        burst("t4b", 2, 3, 1, 1, 16, 16);
        check_val("t4b armed", 32'(ifm.ARMED_O), 1);
        tick();
        check_val("t4b busy after", 32'(ifm.BUSY), 0);
        check_val("t4b trg after",  32'(ifm.TRG_OUT), 0);
        check_val("t4b miss",       32'(ifm.MISS_CNT), 2);
        check_val("t4b evt",        32'(ifm.EVT_CNT), 5);
        ifm.ABORT = 1'b1;
        tick();
        ifm.ABORT = 1'b0;
        check_val("t4b abort armed", 32'(ifm.ARMED_O), 0);

        // Abort mid-pulse with a simultaneous ARM
        set_cfg(0, 10, 1, 1, 0, 1'b1);
        arm();
        burst("t5", 0, 10, 1, 1, 3, 0);
        ifm.ABORT = 1'b1;
        ifm.ARM   = 1'b1;
        tick();
        ifm.ABORT = 1'b0;
        ifm.ARM   = 1'b0;
        check_val("t5 trg",   32'(ifm.TRG_OUT), 0);
        check_val("t5 armed", 32'(ifm.ARMED_O), 0);
        check_val("t5 busy",  32'(ifm.BUSY), 0);
        for (int k = 0; k < 8; k++) begin
            check_val($sformatf("t5 done k=%0d", k), 32'(ifm.DONE), 0);
            check_val($sformatf("t5 idle trg k=%0d", k), 32'(ifm.TRG_OUT), 0);
            tick();
        end
        check_val("t5 evt", 32'(ifm.EVT_CNT), 6);

        // Saturation on the 4-bit status build
        for (int i = 0; i < 20; i++) begin
            ifs.ARM = 1'b1;
            tick();
            ifs.ARM = 1'b0;
            ifs.TRG_IN = 1'b1;
            tick();
            ifs.TRG_IN = 1'b0;
            tick();
            tick();
            tick();
            if (i == 14) check_val("t6 evt at 15", 32'(ifs.EVT_CNT), 15);
        end
        check_val("t6 evt sat",  32'(ifs.EVT_CNT), 15);
        check_val("t6 miss",     32'(ifs.MISS_CNT), 0);

        // Asynchronous reset in the middle of a long delay
        ifs.CFG_DELAY = 16'd50;
        ifs.ARM = 1'b1;
        tick();
        ifs.ARM = 1'b0;
        ifs.TRG_IN = 1'b1;
        tick();
        ifs.TRG_IN = 1'b0;
        tick();
        tick();
        check_val("t6 busy delay", 32'(ifs.BUSY), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t6 ar trg",   32'(ifs.TRG_OUT), 0);
        check_val("t6 ar busy",  32'(ifs.BUSY), 0);
        check_val("t6 ar armed", 32'(ifs.ARMED_O), 0);
        check_val("t6 ar done",  32'(ifs.DONE), 0);
        check_val("t6 ar evt",   32'(ifs.EVT_CNT), 0);
        check_val("t6 ar main evt", 32'(ifm.EVT_CNT), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
